// File: rtl/referee_merge_pkg.sv
// Shared types and constants for the egress referee (4 channel FIFOs -> 1 output FIFO).
// Latency: none, package only.
// Backpressure: none, package only.
package referee_pkg;

  // Number of virtual channels merged and the width of a channel index.
  localparam int NUM_VC     = 4;
  localparam int VC_W       = 2;

  // Default word width of the channel FIFOs and of the merged output.
  localparam int DEF_DATA_W = 12;

  // Grant / channel index.
  typedef logic [VC_W-1:0] vc_idx_t;

  // One-hot strobe vector for the channel FIFO read ports.
  typedef logic [NUM_VC-1:0] vc_mask_t;

  // Binary index -> one-hot strobe vector.
  function automatic vc_mask_t idx_to_onehot(input vc_idx_t idx);
    vc_mask_t oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // One-hot (or all-zero) strobe vector -> binary index.
  // OR-reduction form, so an all-zero vector encodes to 0.
  function automatic vc_idx_t onehot_to_idx(input vc_mask_t oh);
    vc_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (oh[i]) begin
        idx = idx | vc_idx_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/referee_merge_rr_pick4.sv
// Combinational round-robin picker: first set request after the pointer, scanning ptr+1 .. ptr+4.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller qualifies found_o with its own stall. Macro REFEREE_MERGE_PRIO0_EN gives request 0 strict priority.
module rr_pick4
  import referee_pkg::*;
(
  input  vc_mask_t req_i,
  input  vc_idx_t  ptr_i,
  output logic     found_o,
  output vc_idx_t  idx_o
);

  vc_mask_t rr_req;
  vc_mask_t rot;
  vc_idx_t  start;
  vc_idx_t  off;
  logic     rr_found;

  // Requests that take part in the rotation; with the priority option channel 0 never rotates.
  always_comb begin
    rr_req = req_i;
`ifdef REFEREE_MERGE_PRIO0_EN
    rr_req[0] = 1'b0;
`endif
  end

  // Rotate the request vector so that bit 0 is the channel right after the pointer.
  always_comb begin
    start = ptr_i + 2'd1;
    rot   = '0;
    for (int j = 0; j < NUM_VC; j++) begin
      rot[j] = rr_req[start + vc_idx_t'(j)];
    end
  end

  // Lowest set bit of the rotated vector is the winner's offset from start.
  always_comb begin
    rr_found = 1'b0;
    off      = '0;
    for (int j = NUM_VC - 1; j >= 0; j--) begin
      if (rot[j]) begin
        rr_found = 1'b1;
        off      = vc_idx_t'(j);
      end
    end
  end

  // Final pick: rotation winner, overridden by channel 0 when it has strict priority.
  always_comb begin
    found_o = rr_found;
    idx_o   = start + off;
`ifdef REFEREE_MERGE_PRIO0_EN
    if (req_i[0]) begin
      found_o = 1'b1;
      idx_o   = '0;
    end
`endif
  end

endmodule

// File: rtl/referee_merge.sv
// Round-robin merge of four channel FIFOs into one output FIFO, tagging each word with its channel.
// Latency: grant decided at edge k -> pop in cycle k+1 -> push/data_out in cycle k+3 (pop-to-push 2 cycles).
// Backpressure: almost_full blocks new grants only; up to 2 in-flight words still push. Macro REFEREE_MERGE_PRIO0_EN makes channel 0 strict priority.
module referee_merge
  import referee_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              empty_3,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic              almost_full,
  output logic              pop_0,
  output logic              pop_1,
  output logic              pop_2,
  output logic              pop_3,
  output logic              push,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        vc_out
);

  // Grant stage state.
  vc_mask_t          pop_q, pop_d;
  vc_idx_t           last_grant_q, last_grant_d;

  // Read pipeline: which channel was popped last cycle.
  logic              vld_d1_q, vld_d1_d;
  vc_idx_t           sel_d1_q, sel_d1_d;

  // Output registers.
  logic              push_q, push_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  vc_idx_t           vc_out_q, vc_out_d;

  // Flattened channel inputs.
  vc_mask_t          empty_vec;
  vc_mask_t          elig;
  logic [DATA_W-1:0] data_in_arr [NUM_VC];

  logic              grant_found;
  vc_idx_t           grant_idx;
  logic              grant_vld;

  assign empty_vec      = {empty_3, empty_2, empty_1, empty_0};
  assign data_in_arr[0] = data_in_0;
  assign data_in_arr[1] = data_in_1;
  assign data_in_arr[2] = data_in_2;
  assign data_in_arr[3] = data_in_3;

  // A channel popped this cycle still shows its pre-pop empty flag, so it sits out one cycle.
  assign elig      = ~empty_vec & ~pop_q;

  rr_pick4 u_pick (
    .req_i   (elig),
    .ptr_i   (last_grant_q),
    .found_o (grant_found),
    .idx_o   (grant_idx)
  );

  assign grant_vld = grant_found & ~almost_full;

  // Grant decision: next pop strobe and round-robin pointer update.
  always_comb begin
    pop_d        = '0;
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      pop_d = idx_to_onehot(grant_idx);
`ifdef REFEREE_MERGE_PRIO0_EN
      // Priority grants to channel 0 leave the rotation among 1..3 undisturbed.
      if (grant_idx != '0) begin
        last_grant_d = grant_idx;
      end
`else
      last_grant_d = grant_idx;
`endif
    end
  end

  // Read pipeline: remember which channel's data arrives next cycle.
  always_comb begin
    vld_d1_d = |pop_q;
    sel_d1_d = onehot_to_idx(pop_q);
  end

  // Capture: push the arriving word with its channel tag, otherwise hold the last word.
  always_comb begin
    push_d     = vld_d1_q;
    data_out_d = data_out_q;
    vc_out_d   = vc_out_q;
    if (vld_d1_q) begin
      data_out_d = data_in_arr[sel_d1_q];
      vc_out_d   = sel_d1_q;
    end
  end

  // Grant stage registers; pointer resets to 3 so channel 0 is served first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_q        <= '0;
      last_grant_q <= vc_idx_t'(NUM_VC - 1);
    end else begin
      pop_q        <= pop_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Read pipeline registers; in-flight words are dropped by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_d1_q <= 1'b0;
      sel_d1_q <= '0;
    end else begin
      vld_d1_q <= vld_d1_d;
      sel_d1_q <= sel_d1_d;
    end
  end

  // Output registers toward the output FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q     <= 1'b0;
      data_out_q <= '0;
      vc_out_q   <= '0;
    end else begin
      push_q     <= push_d;
      data_out_q <= data_out_d;
      vc_out_q   <= vc_out_d;
    end
  end

  assign pop_0    = pop_q[0];
  assign pop_1    = pop_q[1];
  assign pop_2    = pop_q[2];
  assign pop_3    = pop_q[3];
  assign push     = push_q;
  assign data_out = data_out_q;
  assign vc_out   = vc_out_q;

endmodule

// File: tb/tb_referee_merge.sv
// Bench for referee_merge: channel FIFOs and a cycle-level reference model of the merge live here.
// Latency: model predicts pops one cycle after each grant decision and pushes two cycles after each pop.
// Backpressure: almost_full is driven directly by the stimulus.
module tb_referee_merge;
  import referee_pkg::*;

  localparam int W = DEF_DATA_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    e = 4'hF;
  logic [W-1:0]  rd [4];
  logic          almost_full = 1'b0;

  logic          empty_0, empty_1, empty_2, empty_3;
  logic [W-1:0]  data_in_0, data_in_1, data_in_2, data_in_3;
  logic          pop_0, pop_1, pop_2, pop_3, push;
  logic [W-1:0]  data_out;
  logic [1:0]    vc_out;

  assign empty_0   = e[0];
  assign empty_1   = e[1];
  assign empty_2   = e[2];
  assign empty_3   = e[3];
  assign data_in_0 = rd[0];
  assign data_in_1 = rd[1];
  assign data_in_2 = rd[2];
  assign data_in_3 = rd[3];

  always #5 clk = ~clk;

  referee_merge #(.DATA_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .empty_0     (empty_0),
    .empty_1     (empty_1),
    .empty_2     (empty_2),
    .empty_3     (empty_3),
    .data_in_0   (data_in_0),
    .data_in_1   (data_in_1),
    .data_in_2   (data_in_2),
    .data_in_3   (data_in_3),
    .almost_full (almost_full),
    .pop_0       (pop_0),
    .pop_1       (pop_1),
    .pop_2       (pop_2),
    .pop_3       (pop_3),
    .push        (push),
    .data_out    (data_out),
    .vc_out      (vc_out)
  );

  int checks = 0;
  int errors = 0;

  // Channel FIFO contents seen by the DUT, and the model's own copy of every word.
  logic [W-1:0] fifo_q [4][$];
  logic [W-1:0] exp_q  [4][$];
  int           pend = -1;

  // Stimulus controls.
  bit [3:0] keep_mask = 4'h0;
  bit [3:0] rand_mask = 4'h0;
  bit       rst_drive = 1'b1;
  bit       af_drive  = 1'b0;

  // Reference model: expected values for the current cycle.
  int           m_last;
  int           m_pop;
  logic [W-1:0] m_popword;
  bit           m_vld1;
  int           m_sel1;
  logic [W-1:0] m_word1;
  bit           m_push;
  int           m_vc;
  logic [W-1:0] m_data;

  int last_dp, last_mp, push_cnt;

  int rot     [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int skip    [6] = '{1, 3, 1, 3, 1, 3};
  int single  [10] = '{2, -1, 2, -1, 2, -1, -1, -1, -1, -1};
  int pri01   [6] = '{0, 1, 0, 1, 0, 1};
`ifdef REFEREE_MERGE_PRIO0_EN
  int pri012  [6] = '{0, 1, 0, 2, 0, 1};
`else
  int pri012  [6] = '{0, 1, 2, 0, 1, 2};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int dut_pop();
    logic [3:0] v;
    v = {pop_3, pop_2, pop_1, pop_0};
    case (v)
      4'b0000: return -1;
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -2;
    endcase
  endfunction

  // Round-robin rule: first eligible channel after the last one served.
  function automatic int model_grant(input bit [3:0] el_in, input int last);
    bit [3:0] el;
    el = el_in;
`ifdef REFEREE_MERGE_PRIO0_EN
    if (el[0]) return 0;
    el[0] = 1'b0;
`endif
    for (int i = 1; i <= 4; i++) begin
      if (el[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_last = 3; m_pop = -1; m_popword = '0;
    m_vld1 = 1'b0; m_sel1 = 0; m_word1 = '0;
    m_push = 1'b0; m_vc = 0; m_data = '0;
  endfunction

  function automatic void add_word(input int c);
    logic [W-1:0] w;
    w = W'($urandom);
    fifo_q[c].push_back(w);
    exp_q[c].push_back(w);
  endfunction

  // One clock cycle: compare, serve FIFO reads, refill, drive inputs, advance the model.
  task automatic step();
    int           g;
    bit [3:0]     el;
    bit           n_push, n_vld1;
    int           n_vc, n_sel1;
    logic [W-1:0] n_data, n_word1;
    @(negedge clk);
    last_dp = dut_pop();
    last_mp = m_pop;
    chk("pop", last_dp, m_pop);
    chk("push", push, m_push);
    chk("vc_out", vc_out, m_vc);
    chk("data_out", data_out, m_data);
    if (push) push_cnt++;
    // A pop seen in the previous cycle updates that FIFO's read data and level now.
    if (pend >= 0 && fifo_q[pend].size() > 0) rd[pend] = fifo_q[pend].pop_front();
    pend = (last_dp >= 0) ? last_dp : -1;
    for (int c = 0; c < 4; c++) begin
      if (keep_mask[c] && fifo_q[c].size() < 3) add_word(c);
      else if (rand_mask[c] && fifo_q[c].size() < 4 && $urandom_range(0, 99) < 40) add_word(c);
      e[c] = (fifo_q[c].size() == 0);
    end
    almost_full = af_drive;
    reset = rst_drive;
    if (reset) begin
      model_reset();
    end else begin
      n_push = m_vld1;
      n_vc   = m_vld1 ? m_sel1  : m_vc;
      n_data = m_vld1 ? m_word1 : m_data;
      n_vld1 = (m_pop >= 0);
      n_sel1 = (m_pop >= 0) ? m_pop : m_sel1;
      n_word1 = (m_pop >= 0) ? m_popword : m_word1;
      for (int c = 0; c < 4; c++) el[c] = !e[c] && (m_pop != c);
      g = almost_full ? -1 : model_grant(el, m_last);
      if (g >= 0) begin
        m_popword = (exp_q[g].size() > 0) ? exp_q[g].pop_front() : '0;
`ifdef REFEREE_MERGE_PRIO0_EN
        if (g != 0) m_last = g;
`else
        m_last = g;
`endif
      end
      m_pop  = g;
      m_push = n_push; m_vc = n_vc; m_data = n_data;
      m_vld1 = n_vld1; m_sel1 = n_sel1; m_word1 = n_word1;
    end
  endtask

  // Assert reset in the middle of a cycle and check outputs clear without a clock edge.
  task automatic assert_reset_now();
    rst_drive = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_pops", {pop_3, pop_2, pop_1, pop_0}, 0);
    chk("rst_push", push, 0);
    chk("rst_data", data_out, 0);
    chk("rst_vc", vc_out, 0);
    for (int c = 0; c < 4; c++) begin
      fifo_q[c].delete();
      exp_q[c].delete();
    end
    e = 4'hF;
    pend = -1;
    keep_mask = '0; rand_mask = '0; af_drive = 1'b0;
    model_reset();
  endtask

  task automatic fresh(input bit [3:0] km);
    assert_reset_now();
    step();
    rst_drive = 1'b0;
    keep_mask = km;
    step();
  endtask

  initial begin
    for (int c = 0; c < 4; c++) rd[c] = '0;
    model_reset();
    #1;
    chk("init_pops", {pop_3, pop_2, pop_1, pop_0}, 0);
    chk("init_push", push, 0);

    // Reset mid-transfer with pop_2 high, then first pop after release is channel 0.
    step();
    rst_drive = 1'b0; keep_mask = 4'b0100; step();
    step();
    chk("t1_pop2_high", pop_2, 1);
    assert_reset_now();
    step();
    rst_drive = 1'b0; keep_mask = 4'hF; step();
    step();
    chk("t1_first_pop", last_dp, 0);

    // Full rotation with pushes two cycles behind.
    fresh(4'hF);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rot_dut", last_dp, rot[i]);
      chk("rot_mdl", last_mp, rot[i]);
      if (i >= 2) begin
        chk("rot_push", push, 1);
        chk("rot_vc", vc_out, rot[i-2]);
      end
    end

    // Only channels 1 and 3 hold data.
    fresh(4'b1010);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("skip_dut", last_dp, skip[i]);
      chk("skip_mdl", last_mp, skip[i]);
    end

    // Lone channel 2 with exactly three words.
    fresh(4'b0000);
    for (int k = 0; k < 3; k++) add_word(2);
    step();
    push_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("single_dut", last_dp, single[i]);
      chk("single_mdl", last_mp, single[i]);
    end
    chk("single_pushes", push_cnt, 3);

    // Backpressure during rotation: pops stop, two words drain, rotation resumes.
    fresh(4'hF);
    step(); step(); step();
    af_drive = 1'b1;
    step();
    chk("bp_last_pop", last_dp, 3);
    push_cnt = 0;
    step();
    chk("bp_stop", last_dp, -1);
    for (int i = 0; i < 4; i++) step();
    chk("bp_inflight", push_cnt, 2);
    af_drive = 1'b0;
    step();
    step();
    chk("bp_resume", last_dp, 0);

    // Channels 0 and 1, then 0, 1 and 2 always non-empty.
    fresh(4'b0011);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("pri01_dut", last_dp, pri01[i]);
      chk("pri01_mdl", last_mp, pri01[i]);
    end
    fresh(4'b0111);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("pri012_dut", last_dp, pri012[i]);
      chk("pri012_mdl", last_mp, pri012[i]);
    end

    // Randomized traffic and backpressure against the model.
    fresh(4'b0000);
    rand_mask = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      af_drive = ($urandom_range(0, 99) < 15);
      step();
    end
    rand_mask = 4'h0;
    af_drive = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("drain_ch0", fifo_q[0].size(), 0);
    chk("drain_ch3", fifo_q[3].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/referee_merge.md
# referee_merge

Egress-side round-robin arbiter for the transaction layer: drains four per-channel FIFOs (channels 0–3) into a single output FIFO. It is the mirror of the ingress referee, which splits one FIFO into four. Per cycle it grants at most one non-empty channel, pops it, captures the word one cycle later, and pushes it with its channel tag into the output FIFO. Backpressure comes from the output FIFO's almost-full flag.

## Interface
- `DATA_W`, default 12: word width of every channel FIFO and of the output.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `empty_0`..`empty_3` input, 1 bit each: channel FIFO empty flags.
- `data_in_0`..`data_in_3` input, DATA_W each: channel FIFO read data, valid the cycle after that FIFO's pop.
- `almost_full` input, 1 bit: output FIFO almost full. Must assert with at least 2 free entries.
- `pop_0`..`pop_3` output, 1 bit each: channel FIFO read strobes. Registered; at most one high per cycle.
- `push` output, 1 bit: output FIFO write strobe. Registered.
- `data_out` output, DATA_W: word to the output FIFO. Registered.
- `vc_out` output, 2 bits: source channel of `data_out`. Registered.

## Operation
- **State.** `last_grant[1:0]` holds the last granted channel; reset value 3, so channel 0 has first priority. `sel_d1[1:0]` and `vld_d1` form the one-stage read pipeline.
- **Eligibility.** Channel c is eligible when `empty_c` = 0 and `pop_c` is not currently high. The second condition prevents a stale-empty double pop, so a lone active channel is popped every other cycle.
- **Grant.** When `almost_full` = 0, the first eligible channel scanning `last_grant+1`, `+2`, `+3`, `+4` (mod 4) is granted. On the next edge its `pop_c` goes to 1 and `last_grant` takes c. With no eligible channel, or with `almost_full` = 1, all pops go to 0 and `last_grant` holds.
- **Capture.** On each edge, `vld_d1` takes the OR of the pops and `sel_d1` takes the encoded channel. When `vld_d1` = 1, the next edge loads `data_out` from `data_in_[sel_d1]`, loads `vc_out` from `sel_d1`, and sets `push` to 1. Otherwise `push` goes to 0 and `data_out`/`vc_out` hold.
- **Backpressure.** `almost_full` only blocks new grants. The up to 2 words already in flight always complete, which is why the 2-entry almost-full margin is required.
- **Reset.** All outputs and `vld_d1` go to 0 and `last_grant` goes to 3. Reset is asynchronous, including mid-transfer; in-flight words are dropped and not replayed.

## Timing
- A grant decided in cycle k from the `empty`/`almost_full` values sampled at the edge closing cycle k gives `pop_c` high in cycle k+1. `data_in_c` is valid in cycle k+2, and `push`/`data_out` are high in cycle k+3.
- Pop-to-push latency is 2 cycles.
- Throughput is 1 word per cycle when at least 2 channels are non-empty, and 1 word per 2 cycles when a single channel is active.
- `push` asserts for one cycle per word, never more.
- A change of `almost_full` takes effect on `pop_*` at the next edge.

## Configuration
- Macro `REFEREE_MERGE_PRIO0_EN`.
- **Defined:** channel 0 is strict priority. Whenever channel 0 is eligible it is granted regardless of `last_grant`, and `last_grant` is not updated. Channels 1–3 round-robin among themselves when channel 0 is not eligible.
- **Undefined:** pure 4-way round-robin as described in Operation.

## Structure
- Shared package `referee_pkg`: `NUM_VC` = 4, `VC_W` = 2, default `DATA_W` = 12, and the grant-index typedef.
- One sub-module, `rr_pick4`: combinational 4-bit request plus 2-bit pointer in, 1-bit found plus 2-bit index out, with the priority-0 override under the macro.
- The top holds the registers and the data mux.

## Test plan
1. **Reset.** Assert `reset` mid-transfer with `pop_2` = 1 -> all outputs 0 immediately. After release with all channels non-empty, the first pop is `pop_0`.
2. **Full rotation.** All channels non-empty, `almost_full` = 0 -> pops 0,1,2,3,0,… on consecutive cycles. `push` follows 2 cycles later with `vc_out` in the same sequence, and `data_out` matches the FIFO contents.
3. **Skip empty.** Only channels 1 and 3 non-empty -> pops alternate 1,3,1,3.
4. **Single channel.** Only channel 2 non-empty, holding 3 words -> `pop_2` high every other cycle, 3 pushes total, no pop while `empty_2` = 1.
5. **Backpressure.** Raise `almost_full` during a rotation -> pops stop next cycle, exactly the in-flight words (≤ 2) are pushed afterwards. On drop, rotation resumes from `last_grant+1`.
6. **Priority macro.** `REFEREE_MERGE_PRIO0_EN` defined, channels 0 and 1 always non-empty -> pops 0,1,0,1. With the macro undefined, same stimulus also gives 0,1,0,1 (round-robin). With channels 0, 1, 2 all non-empty: macro -> 0,1,0,2,…; no macro -> 0,1,2,….
